id_stage_reg: RTL and testbench

ID_STAGE_REG -- requirements
Module: id_stage_reg

---
 rtl/id_stage_reg_pkg.sv | 45 ++++
 rtl/id_stage_reg_if.sv | 47 ++++
 rtl/id_stage_reg_pipe_field_reg.sv | 29 ++
 rtl/id_stage_reg.sv | 95 +++++++++
 tb/tb_id_stage_reg.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/id_stage_reg_pkg.sv
// rtl/id_stage_reg_pkg.sv - shared ARM field widths, constants and ID/EXE register types
package id_stage_reg_pkg;

    localparam int PC_W       = 32;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 4;
    localparam int EXE_CMD_W  = 4;
    localparam int SHIFT_OP_W = 12;
    localparam int IMM24_W    = 24;
    localparam int STATUS_W   = 4;

    localparam logic [EXE_CMD_W-1:0] EXE_CMD_NOP = 4'b0000;

    typedef enum logic {
        OCC_EMPTY = 1'b0,
        OCC_FULL  = 1'b1
    } occ_state_e;

    typedef struct packed {
        logic [PC_W-1:0]       pc;
        logic [DATA_W-1:0]     val_rn;
        logic [DATA_W-1:0]     val_rm;
        logic                  imm;
        logic [SHIFT_OP_W-1:0] shift_operand;
        logic [IMM24_W-1:0]    signed_imm24;
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_ADDR_W-1:0] src1;
        logic [REG_ADDR_W-1:0] src2;
        logic [STATUS_W-1:0]   status;
    } id_data_t;

    // Controls that change architectural or memory state downstream.
    typedef struct packed {
        logic mem_r_en;
        logic mem_w_en;
        logic wb_en;
        logic b;
        logic s;
    } id_ctrl_t;

    function automatic id_ctrl_t gate_ctrl(input id_ctrl_t c, input logic valid);
        return valid ? c : '0;
    endfunction

endpackage

// File: rtl/id_stage_reg_if.sv
// rtl/id_stage_reg_if.sv - ID/EXE pipeline register bus: decoded fields in, registered fields out
interface id_stage_reg_if;
    import id_stage_reg_pkg::*;

    logic                  freeze;
    logic                  flush;

    logic [PC_W-1:0]       pc_in,              pc_out;
    logic [DATA_W-1:0]     val_rn_in,          val_rn_out;
    logic [DATA_W-1:0]     val_rm_in,          val_rm_out;
    logic                  imm_in,             imm_out;
    logic [SHIFT_OP_W-1:0] shift_operand_in,   shift_operand_out;
    logic [IMM24_W-1:0]    signed_imm24_in,    signed_imm24_out;
    logic [REG_ADDR_W-1:0] dest_in,            dest_out;
    logic [REG_ADDR_W-1:0] src1_in,            src1_out;
    logic [REG_ADDR_W-1:0] src2_in,            src2_out;
    logic [EXE_CMD_W-1:0]  exe_cmd_in,         exe_cmd_out;
    logic                  mem_r_en_in,        mem_r_en_out;
    logic                  mem_w_en_in,        mem_w_en_out;
    logic                  wb_en_in,           wb_en_out;
    logic                  b_in,               b_out;
    logic                  s_in,               s_out;
    logic [STATUS_W-1:0]   status_in,          status_out;
    logic                  valid_in,           valid_out;
    logic                  is_mem;

    modport master (
        output freeze, flush,
        output pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in, signed_imm24_in,
        output dest_in, src1_in, src2_in, exe_cmd_in, mem_r_en_in, mem_w_en_in,
        output wb_en_in, b_in, s_in, status_in, valid_in,
        input  pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out, signed_imm24_out,
        input  dest_out, src1_out, src2_out, exe_cmd_out, mem_r_en_out, mem_w_en_out,
        input  wb_en_out, b_out, s_out, status_out, valid_out, is_mem
    );

    modport slave (
        input  freeze, flush,
        input  pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in, signed_imm24_in,
        input  dest_in, src1_in, src2_in, exe_cmd_in, mem_r_en_in, mem_w_en_in,
        input  wb_en_in, b_in, s_in, status_in, valid_in,
        output pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out, signed_imm24_out,
        output dest_out, src1_out, src2_out, exe_cmd_out, mem_r_en_out, mem_w_en_out,
        output wb_en_out, b_out, s_out, status_out, valid_out, is_mem
    );

endinterface

// File: rtl/id_stage_reg_pipe_field_reg.sv
// rtl/id_stage_reg_pipe_field_reg.sv - parameterised pipeline field register with rst/clear/hold
module pipe_field_reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             hold_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] field_q;

    // Clear beats hold so a squash always discards frozen contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            field_q <= CLEAR_VAL;
        end else if (clear_i) begin
            field_q <= CLEAR_VAL;
        end else if (!hold_i) begin
            field_q <= d_i;
        end
    end

    assign q_o = field_q;

endmodule

// File: rtl/id_stage_reg.sv
// rtl/id_stage_reg.sv - ID/EXE pipeline register with flush/freeze and EMPTY/FULL occupancy
module id_stage_reg
    import id_stage_reg_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    id_stage_reg_if.slave bus
);

    id_data_t             data_d, data_q;
    id_ctrl_t             ctrl_d, ctrl_q;
    logic [EXE_CMD_W-1:0] cmd_q;
    occ_state_e           state_q;

    assign data_d = '{
        pc:            bus.pc_in,
        val_rn:        bus.val_rn_in,
        val_rm:        bus.val_rm_in,
        imm:           bus.imm_in,
        shift_operand: bus.shift_operand_in,
        signed_imm24:  bus.signed_imm24_in,
        dest:          bus.dest_in,
        src1:          bus.src1_in,
        src2:          bus.src2_in,
        status:        bus.status_in
    };

    // An invalid slot must never carry live side effects into EXE.
    assign ctrl_d = gate_ctrl('{
        mem_r_en: bus.mem_r_en_in,
        mem_w_en: bus.mem_w_en_in,
        wb_en:    bus.wb_en_in,
        b:        bus.b_in,
        s:        bus.s_in
    }, bus.valid_in);

    pipe_field_reg #(.WIDTH($bits(id_data_t))) u_data_reg (
        .clk     (clk),
        .rst     (rst),
        .clear_i (bus.flush),
        .hold_i  (bus.freeze),
        .d_i     (data_d),
        .q_o     (data_q)
    );

    pipe_field_reg #(.WIDTH($bits(id_ctrl_t))) u_ctrl_reg (
        .clk     (clk),
        .rst     (rst),
        .clear_i (bus.flush),
        .hold_i  (bus.freeze),
        .d_i     (ctrl_d),
        .q_o     (ctrl_q)
    );

    pipe_field_reg #(.WIDTH(EXE_CMD_W), .CLEAR_VAL(EXE_CMD_NOP)) u_cmd_reg (
        .clk     (clk),
        .rst     (rst),
        .clear_i (bus.flush),
        .hold_i  (bus.freeze),
        .d_i     (bus.exe_cmd_in),
        .q_o     (cmd_q)
    );

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            state_q <= OCC_EMPTY;
        end else if (!bus.freeze) begin
            case (state_q)
                OCC_EMPTY: if (bus.valid_in)  state_q <= OCC_FULL;
                OCC_FULL:  if (!bus.valid_in) state_q <= OCC_EMPTY;
                default:                      state_q <= OCC_EMPTY;
            endcase
        end
    end

    assign bus.pc_out            = data_q.pc;
    assign bus.val_rn_out        = data_q.val_rn;
    assign bus.val_rm_out        = data_q.val_rm;
    assign bus.imm_out           = data_q.imm;
    assign bus.shift_operand_out = data_q.shift_operand;
    assign bus.signed_imm24_out  = data_q.signed_imm24;
    assign bus.dest_out          = data_q.dest;
    assign bus.src1_out          = data_q.src1;
    assign bus.src2_out          = data_q.src2;
    assign bus.status_out        = data_q.status;
    assign bus.exe_cmd_out       = cmd_q;
    assign bus.mem_r_en_out      = ctrl_q.mem_r_en;
    assign bus.mem_w_en_out      = ctrl_q.mem_w_en;
    assign bus.wb_en_out         = ctrl_q.wb_en;
    assign bus.b_out             = ctrl_q.b;
    assign bus.s_out             = ctrl_q.s;
    assign bus.valid_out         = (state_q == OCC_FULL);
    assign bus.is_mem            = ctrl_q.mem_r_en | ctrl_q.mem_w_en;

endmodule

// File: tb/tb_id_stage_reg.sv
// tb/tb_id_stage_reg.sv - scoreboard bench for the ID/EXE pipeline register
module tb_id_stage_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic        imm;
        logic [11:0] shop;
        logic [23:0] imm24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  cmd;
        logic        mem_r;
        logic        mem_w;
        logic        wb;
        logic        b;
        logic        s;
        logic [3:0]  status;
        logic        valid;
        logic        is_mem;
    } obs_t;

    logic clk = 1'b0;
    logic rst;

    id_stage_reg_if bus ();

    id_stage_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    obs_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic clr();
        bus.freeze = 0; bus.flush = 0;
        bus.pc_in = '0; bus.val_rn_in = '0; bus.val_rm_in = '0; bus.imm_in = 0;
        bus.shift_operand_in = '0; bus.signed_imm24_in = '0; bus.dest_in = '0;
        bus.src1_in = '0; bus.src2_in = '0; bus.exe_cmd_in = '0; bus.mem_r_en_in = 0;
        bus.mem_w_en_in = 0; bus.wb_en_in = 0; bus.b_in = 0; bus.s_in = 0;
        bus.status_in = '0; bus.valid_in = 0;
    endtask

    task automatic step(input obs_t e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: every edge that has an outstanding expectation is checked.
    initial begin
        obs_t  act, e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = '{pc: bus.pc_out, rn: bus.val_rn_out, rm: bus.val_rm_out,
                        imm: bus.imm_out, shop: bus.shift_operand_out,
                        imm24: bus.signed_imm24_out, dest: bus.dest_out,
                        src1: bus.src1_out, src2: bus.src2_out, cmd: bus.exe_cmd_out,
                        mem_r: bus.mem_r_en_out, mem_w: bus.mem_w_en_out,
                        wb: bus.wb_en_out, b: bus.b_out, s: bus.s_out,
                        status: bus.status_out, valid: bus.valid_out, is_mem: bus.is_mem};
                n_checks++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", nm, act, e);
                end
            end
        end
    end

    initial begin
        obs_t e, held;

        // Reset with every input busy, including freeze.
        clr();
        rst = 1;
        bus.freeze = 1; bus.pc_in = 32'hFFFF_FFFF; bus.wb_en_in = 1; bus.valid_in = 1;
        bus.mem_w_en_in = 1; bus.exe_cmd_in = 4'hF;
        e = '0;
        step(e, "reset");

        rst = 0;
        clr();
        bus.pc_in = 32'h10; bus.val_rm_in = 32'hDEAD_BEEF; bus.wb_en_in = 1; bus.valid_in = 1;
        e = '0; e.pc = 32'h10; e.rm = 32'hDEAD_BEEF; e.wb = 1; e.valid = 1;
        held = e;
        step(e, "load");

        bus.freeze = 1; bus.pc_in = 32'h20;
        for (int i = 0; i < 3; i++) step(held, "freeze_hold");

        bus.freeze = 0;
        e = held; e.pc = 32'h20;
        step(e, "unfreeze_load");

        clr();
        bus.pc_in = 32'h30; bus.mem_w_en_in = 1; bus.exe_cmd_in = 4'h5;
        bus.status_in = 4'hA; bus.valid_in = 1;
        e = '0; e.pc = 32'h30; e.mem_w = 1; e.cmd = 4'h5; e.status = 4'hA;
        e.valid = 1; e.is_mem = 1;
        step(e, "store_load");

        bus.flush = 1; bus.freeze = 1;
        e = '0;
        step(e, "flush_over_freeze");

        clr();
        bus.valid_in = 0; bus.wb_en_in = 1; bus.mem_r_en_in = 1; bus.pc_in = 32'h40;
        bus.dest_in = 4'h7; bus.b_in = 1; bus.s_in = 1; bus.mem_w_en_in = 1;
        e = '0; e.pc = 32'h40; e.dest = 4'h7;
        step(e, "invalid_input");

        clr();
        bus.pc_in = 32'h50; bus.val_rn_in = 32'h1234_5678; bus.dest_in = 4'h2;
        bus.src1_in = 4'h4; bus.src2_in = 4'h5; bus.exe_cmd_in = 4'h9;
        bus.wb_en_in = 1; bus.b_in = 1; bus.s_in = 1; bus.valid_in = 1;
        e = '0; e.pc = 32'h50; e.rn = 32'h1234_5678; e.dest = 4'h2; e.src1 = 4'h4;
        e.src2 = 4'h5; e.cmd = 4'h9; e.wb = 1; e.b = 1; e.s = 1; e.valid = 1;
        step(e, "full_load");

        rst = 1; bus.freeze = 1; bus.pc_in = 32'h60;
        e = '0;
        step(e, "reset_priority");

        bus.freeze = 0; bus.pc_in = 32'h70; bus.mem_r_en_in = 1;
        step(e, "reset_held");

        rst = 0; bus.freeze = 1; bus.pc_in = 32'h80;
        step(e, "post_reset_freeze");

        clr();
        bus.imm_in = 1; bus.shift_operand_in = 12'hF0F; bus.mem_r_en_in = 1;
        bus.signed_imm24_in = 24'h80_0001; bus.valid_in = 1;
        e = '0; e.imm = 1; e.shop = 12'hF0F; e.mem_r = 1; e.imm24 = 24'h80_0001;
        e.valid = 1; e.is_mem = 1;
        held = e;
        step(e, "passthrough");

        bus.freeze = 1; bus.pc_in = 32'h88;
        step(held, "passthrough_hold");

        rst = 1;
        e = '0;
        step(e, "reset_mid_freeze");

        rst = 0;
        clr();
        bus.pc_in = 32'h90; bus.b_in = 1; bus.valid_in = 1;
        e = '0; e.pc = 32'h90; e.b = 1; e.valid = 1;
        step(e, "first_load_after_reset");

        bus.flush = 1; bus.wb_en_in = 1; bus.pc_in = 32'hA0;
        e = '0;
        step(e, "flush_alone");

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
